// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs on the 8-bit I/O bus.
// Four SPI modes, bit order, divider, chip selects, card detect.
module spi_master_fifo #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         NUM_CS     = 2,
  parameter logic [7:0] DIV_RESET  = 8'd63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              wr,
  input  logic              rd,
  input  logic [1:0]        addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              irq,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  input  logic              card_det_n
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state, state_d;

  logic [7:0]    ctrl, div;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic [7:0]    sh_tx, sh_rx, tmr, ldiv;
  logic [3:0]    ecnt;
  logic          lcpol, lcpha, llsb;
  logic          done, card_chg, rx_ovf;
  logic          cd_s1, cd_s2, cd_prev;

  logic       wr_en, rd_en, hit, odd, samp, shout;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop, rx_ok;
  logic       busy, cur_bit, first;
  logic [2:0] w1c;
  logic [7:0] status, ld, ld_shift, sh_next, rx_in;

  assign wr_en    = sel & wr;
  assign rd_en    = sel & rd;
  assign tx_full  = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign rx_full  = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign tx_push  = wr_en && addr == 2'd2 && !tx_full;
  assign rx_pop   = rd_en && addr == 2'd2 && !rx_empty;
  assign rx_ok    = rx_push && !rx_full;
  assign w1c      = (wr_en && addr == 2'd1) ? wdata[6:4] : 3'b000;
  assign busy     = (state != IDLE) || !tx_empty;

  assign status = {1'b0, rx_ovf, card_chg, done,
                   ~cd_s2, rx_empty, tx_full, busy};

  assign hit   = tmr == ldiv;
  assign odd   = ~ecnt[0];
  assign samp  = (state == SHIFT) && hit && (lcpha ? ~odd : odd);
  assign shout = (state == SHIFT) && hit &&
                 (lcpha ? odd : (~odd && ecnt != 4'd15));

  assign ld       = tx_mem[tx_rp];
  assign first    = ctrl[2] ? ld[0] : ld[7];
  assign ld_shift = ctrl[2] ? {1'b0, ld[7:1]} : {ld[6:0], 1'b0};
  assign cur_bit  = llsb ? sh_tx[0] : sh_tx[7];
  assign sh_next  = llsb ? {1'b0, sh_tx[7:1]} : {sh_tx[6:0], 1'b0};
  assign rx_in    = llsb ? {miso, sh_rx[7:1]} : {sh_rx[6:0], miso};

  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      cs_n[i] = ~(ctrl[3] && (ctrl[5:4] == 2'(i)));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state)
      IDLE:  if (!tx_empty) state_d = LOAD;
      LOAD:  begin
        tx_pop  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (hit && ecnt == 4'd15) state_d = GAP;
      GAP:   if (hit) begin
        rx_push = 1'b1;
        state_d = tx_empty ? IDLE : LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_mem <= '{default: '0};
      rx_mem <= '{default: '0};
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= wdata;
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_ok) begin
        rx_mem[rx_wp] <= sh_rx;
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      rx_cnt <= rx_cnt + CW'(rx_ok) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      div      <= DIV_RESET;
      done     <= 1'b0;
      card_chg <= 1'b0;
      rx_ovf   <= 1'b0;
      cd_s1    <= 1'b1;
      cd_s2    <= 1'b1;
      cd_prev  <= 1'b1;
      irq      <= 1'b0;
      rdata    <= '0;
    end else begin
      if (wr_en && addr == 2'd0) ctrl <= wdata;
      if (wr_en && addr == 2'd3) div  <= wdata;
      // set terms are OR-ed last so they beat a same-cycle clear
      done     <= (done & ~w1c[0]) | (rx_push & tx_empty);
      card_chg <= (card_chg & ~w1c[1]) | (cd_s2 != cd_prev);
      rx_ovf   <= (rx_ovf & ~w1c[2]) | (rx_push & rx_full);
      cd_s1    <= card_det_n;
      cd_s2    <= cd_s1;
      cd_prev  <= cd_s2;
      irq      <= (ctrl[6] & done) | (ctrl[7] & card_chg);
      if (rd_en) begin
        unique case (addr)
          2'd0: rdata <= ctrl;
          2'd1: rdata <= status;
          2'd2: rdata <= rx_empty ? 8'h00 : rx_mem[rx_rp];
          2'd3: rdata <= div;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk  <= 1'b0;
      mosi  <= 1'b1;
      sh_tx <= '0;
      sh_rx <= '0;
      tmr   <= '0;
      ldiv  <= '0;
      ecnt  <= '0;
      lcpol <= 1'b0;
      lcpha <= 1'b0;
      llsb  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: sclk <= ctrl[1];
        LOAD: begin
          lcpha <= ctrl[0];
          lcpol <= ctrl[1];
          llsb  <= ctrl[2];
          ldiv  <= div;
          tmr   <= '0;
          ecnt  <= '0;
          sclk  <= ctrl[1];
          // CPHA=0 puts the first bit out before the leading edge
          if (!ctrl[0]) begin
            mosi  <= first;
            sh_tx <= ld_shift;
          end else begin
            sh_tx <= ld;
          end
        end
        SHIFT: begin
          tmr <= hit ? 8'd0 : tmr + 8'd1;
          if (hit) begin
            sclk <= ~sclk;
            ecnt <= ecnt + 4'd1;
          end
          if (samp) sh_rx <= rx_in;
          if (shout) begin
            mosi  <= cur_bit;
            sh_tx <= sh_next;
          end
        end
        GAP: begin
          sclk <= lcpol;
          tmr  <= hit ? 8'd0 : tmr + 8'd1;
          if (hit && tx_empty) mosi <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo with an RX scoreboard.
// Bus driven and outputs sampled on the falling clk edge.
module tb_spi_master_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       irq, sclk, mosi, miso;
  logic [1:0] cs_n;
  logic       card_det_n = 1'b1;
  logic       loop = 1'b0, miso_v = 1'b1;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  assign miso = loop ? mosi : miso_v;

  always #5 clk = ~clk;

  spi_master_fifo #(
    .FIFO_DEPTH(4),
    .NUM_CS(2),
    .DIV_RESET(8'd63)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .wr(wr),
    .rd(rd),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .card_det_n(card_det_n)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a,
                        input logic [7:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a,
                        output logic [7:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic rd_check(input string tag,
                          input logic [1:0] a,
                          input logic [7:0] exp);
    logic [7:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic rx_check(input string tag);
    logic [7:0] d, e;
    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    bus_rd(2'd2, d);
    check(tag, d, e);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] st;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus_rd(2'd1, st);
      if (!st[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  // Records mosi at each rising sclk and the run lengths of the
  // active (non-idle) and idle sclk levels once the frame started.
  task automatic capture(input int n, input logic pol,
                         input int budget,
                         output logic [63:0] bits, output int got,
                         output int amin, output int amax,
                         output int imin, output int imax);
    logic prev;
    int   run;
    bit   started;
    bits = '0; got = 0; run = 0; started = 1'b0;
    amin = 9999; amax = 0; imin = 9999; imax = 0;
    prev = sclk;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (sclk !== prev) begin
        if (started && prev !== pol) begin
          if (run < amin) amin = run;
          if (run > amax) amax = run;
        end else if (started) begin
          if (run < imin) imin = run;
          if (run > imax) imax = run;
        end
        if (prev === pol) started = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      if (prev === 1'b0 && sclk === 1'b1) begin
        got++;
        bits = {bits[62:0], mosi};
      end
      prev = sclk;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits;
    int got, amin, amax, imin, imax, n;
    logic [7:0] st, b;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_cs_n", cs_n, 2'b11);
    check("rst_irq", irq, 0);
    check("rst_rdata", rdata, 0);
    rd_check("rst_ctrl", 2'd0, 8'h00);
    rd_check("rst_div", 2'd3, 8'd63);
    rd_check("rst_status", 2'd1, 8'h04);

    // mode 0, DIV=0, MSB first, loopback
    bus_wr(2'd3, 8'd0);
    bus_wr(2'd0, 8'h08);
    check("t1_cs_n", cs_n, 2'b10);
    loop = 1'b1;
    bus_wr(2'd2, 8'hA5);
    sb.push_back(8'hA5);
    capture(8, 1'b0, 200, bits, got, amin, amax, imin, imax);
    check("t1_pulses", got, 8);
    check("t1_mosi", bits[7:0], 8'hA5);
    check("t1_hi_min", amin, 1);
    check("t1_hi_max", amax, 1);
    wait_idle("t1_idle");
    rd_check("t1_status", 2'd1, 8'h10);
    bus_wr(2'd1, 8'h10);
    rx_check("t1_rx");
    rd_check("t1_empty_st", 2'd1, 8'h04);

    // mode 3, LSB first, DIV=3, miso tied high, cs 1
    loop = 1'b0;
    miso_v = 1'b1;
    bus_wr(2'd3, 8'd3);
    bus_wr(2'd0, 8'h1F);
    @(negedge clk);
    check("t2_idle_hi", sclk, 1);
    check("t2_cs_n", cs_n, 2'b01);
    bus_wr(2'd2, 8'h3C);
    sb.push_back(8'hFF);
    capture(8, 1'b1, 400, bits, got, amin, amax, imin, imax);
    check("t2_pulses", got, 8);
    check("t2_mosi", bits[7:0], 8'h3C);
    check("t2_lo_min", amin, 4);
    check("t2_lo_max", amax, 4);
    check("t2_hi_max", imax, 4);
    wait_idle("t2_idle");
    check("t2_sclk_end", sclk, 1);
    rd_check("t2_status", 2'd1, 8'h10);
    bus_wr(2'd1, 8'h10);
    rx_check("t2_rx");

    // mode 1, LSB first, DIV=1, loopback: bit order both ways
    bus_wr(2'd3, 8'd1);
    bus_wr(2'd0, 8'h0D);
    loop = 1'b1;
    bus_wr(2'd2, 8'h12);
    sb.push_back(8'h12);
    capture(8, 1'b0, 300, bits, got, amin, amax, imin, imax);
    check("t2b_pulses", got, 8);
    check("t2b_mosi", bits[7:0], 8'h48);
    check("t2b_hi", amax, 2);
    wait_idle("t2b_idle");
    bus_wr(2'd1, 8'h10);
    rx_check("t2b_rx");

    // six back-to-back writes: one in flight, four queued, one dropped
    bus_wr(2'd3, 8'd7);
    bus_wr(2'd0, 8'h08);
    for (int i = 0; i < 6; i++) begin
      b = 8'(8'h11 * (i + 1));
      bus_wr(2'd2, b);
      if (i < 4) sb.push_back(b);
    end
    rd_check("t3_full_st", 2'd1, 8'h07);
    capture(40, 1'b0, 2000, bits, got, amin, amax, imin, imax);
    check("t3_pulses", got, 40);
    check("t3_mosi", bits[39:0], 40'h1122334455);
    check("t3_hi", amax, 8);
    check("t3_lo_min", imin, 8);
    check("t3_gap", imax, 17);
    wait_idle("t3_idle");
    rd_check("t3_ovf_st", 2'd1, 8'h50);
    for (int i = 0; i < 4; i++) rx_check("t3_rx");
    rd_check("t3_empty_rd", 2'd2, 8'h00);
    bus_wr(2'd1, 8'h50);
    rd_check("t3_clr_st", 2'd1, 8'h04);

    // card detect insertion with ie_card
    bus_wr(2'd0, 8'h80);
    card_det_n = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (irq) begin
        n = i;
        break;
      end
    end
    check("t5_irq_lat", (n >= 1 && n <= 4), 1);
    rd_check("t5_status", 2'd1, 8'h2C);
    bus_wr(2'd1, 8'h20);
    @(negedge clk);
    check("t5_irq_clr", irq, 0);
    rd_check("t5_clr_st", 2'd1, 8'h0C);
    card_det_n = 1'b1;
    repeat (6) @(negedge clk);

    // reset in the middle of a frame
    bus_wr(2'd3, 8'd5);
    bus_wr(2'd0, 8'h0B);
    bus_wr(2'd2, 8'hFF);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_sclk", sclk, 0);
    check("t6_mosi", mosi, 1);
    check("t6_cs_n", cs_n, 2'b11);
    check("t6_irq", irq, 0);
    check("t6_rdata", rdata, 0);
    rd_check("t6_status", 2'd1, 8'h04);
    rd_check("t6_ctrl", 2'd0, 8'h00);
    rd_check("t6_div", 2'd3, 8'd63);
    rd_check("t6_rx", 2'd2, 8'h00);
    repeat (10) @(negedge clk);
    check("t6_quiet", sclk, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
